// File: rtl/fetch_unit.sv
// fetch_unit -- MIPS instruction fetch stage feeding the main decoder.
//
// Holds the PC and keeps at most one instruction-memory request outstanding.
// The IF/ID register sits between this stage and the decoder. A one-entry skid
// buffer holds a response that arrives while decode is stalled. A branch or
// jump redirect flushes IF/ID, and any fetch still in flight is drained and
// its data thrown away.
//
// Optional build macro: FETCH_PERF_EN adds the fetch_count output, which
// counts IF/ID loads.
//
// Ports:
//   clk, reset                      clock and async active-high reset
//   imem_req, imem_addr             fetch request / address (address = pc)
//   imem_rdata, imem_valid          one-cycle memory response
//   stall                           decode hazard, IF/ID holds
//   branch_taken, branch_target     redirect from the branch unit (wins)
//   jump, jump_target               redirect from decode
//   id_valid, id_instr, id_op,
//   id_pc4                          IF/ID register outputs
//   fetch_count                     (FETCH_PERF_EN only) IF/ID load counter
//
// state   | meaning
// S_IDLE  | just out of reset, no request yet
// S_FETCH | request outstanding at pc
// S_HOLD  | response parked in skid, waiting for stall to drop
// S_DRAIN | redirected mid-request, waiting to discard the stale response
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_valid,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [5:0]  id_op,
    output logic [31:0] id_pc4
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] fetch_count
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t      state, state_n;
    logic [31:0] pc, pc_n;
    logic [31:0] pc_plus4;
    logic        id_valid_n;
    logic [31:0] id_instr_n, id_pc4_n;
    logic [31:0] skid_instr, skid_instr_n;
    logic [31:0] skid_pc4, skid_pc4_n;
    logic        redirect;
    logic [31:0] redirect_tgt;

    assign pc_plus4 = pc + 32'd4;
    assign redirect = (branch_taken | jump) && (state != S_IDLE);
    // Branch is the older instruction, so it takes priority over a jump.
    assign redirect_tgt = (branch_taken ? branch_target : jump_target) & 32'hFFFF_FFFC;

    assign imem_addr = pc;
    assign id_op     = id_instr[31:26];

    always_comb begin
        state_n      = state;
        pc_n         = pc;
        // A consumed entry becomes a bubble unless something new is loaded.
        id_valid_n   = stall ? id_valid : 1'b0;
        id_instr_n   = id_instr;
        id_pc4_n     = id_pc4;
        skid_instr_n = skid_instr;
        skid_pc4_n   = skid_pc4;
        imem_req     = 1'b0;

        case (state)
            S_IDLE: begin
                state_n = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_valid) begin
                    pc_n = pc_plus4;
                    if (!stall) begin
                        id_valid_n = 1'b1;
                        id_instr_n = imem_rdata;
                        id_pc4_n   = pc_plus4;
                    end else begin
                        skid_instr_n = imem_rdata;
                        skid_pc4_n   = pc_plus4;
                        state_n      = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (!stall) begin
                    id_valid_n = 1'b1;
                    id_instr_n = skid_instr;
                    id_pc4_n   = skid_pc4;
                    state_n    = S_FETCH;
                end
            end
            S_DRAIN: begin
                if (imem_valid) begin
                    state_n = S_FETCH;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        // Flush beats stall. Anything decided above for this cycle is dropped.
        // A request that is still in flight has to be drained first.
        if (redirect) begin
            pc_n         = redirect_tgt;
            id_valid_n   = 1'b0;
            id_instr_n   = id_instr;
            id_pc4_n     = id_pc4;
            skid_instr_n = 32'd0;
            skid_pc4_n   = 32'd0;
            state_n      = (state == S_FETCH && !imem_valid) ? S_DRAIN : S_FETCH;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            pc         <= RESET_PC;
            id_valid   <= 1'b0;
            id_instr   <= 32'd0;
            id_pc4     <= 32'd0;
            skid_instr <= 32'd0;
            skid_pc4   <= 32'd0;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            id_valid   <= id_valid_n;
            id_instr   <= id_instr_n;
            id_pc4     <= id_pc4_n;
            skid_instr <= skid_instr_n;
            skid_pc4   <= skid_pc4_n;
        end
    end

`ifdef FETCH_PERF_EN
    logic load_id;

    assign load_id = !redirect && !stall &&
                     ((state == S_FETCH && imem_valid) || state == S_HOLD);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_count <= 32'd0;
        end else if (load_id) begin
            fetch_count <= fetch_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit -- scoreboard bench for fetch_unit.
// The stimulus pushes the expected IF/ID entries into a queue. A monitor pops
// one entry each time decode consumes an IF/ID entry (id_valid high, stall low)
// and compares it with what the DUT shows. A second instance with
// RESET_PC = 0xFFFF_FFFC covers PC wrap-around.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'd0;
    logic        imem_valid = 1'b0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'd0;
    logic        jump = 1'b0;
    logic [31:0] jump_target = 32'd0;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [5:0]  id_op;
    logic [31:0] id_pc4;

    logic        imem_req2;
    logic [31:0] imem_addr2;
    logic        imem_valid2;
    logic        id_valid2;
    logic [31:0] id_instr2;
    logic [5:0]  id_op2;
    logic [31:0] id_pc42;
`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count;
    logic [31:0] fetch_count2;
`endif

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_valid(imem_valid),
        .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target),
        .id_valid(id_valid), .id_instr(id_instr), .id_op(id_op), .id_pc4(id_pc4)
`ifdef FETCH_PERF_EN
        , .fetch_count(fetch_count)
`endif
    );

    // Zero-wait memory that returns the address as data.
    assign imem_valid2 = imem_req2;

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk(clk), .reset(reset),
        .imem_req(imem_req2), .imem_addr(imem_addr2),
        .imem_rdata(imem_addr2), .imem_valid(imem_valid2),
        .stall(1'b0),
        .branch_taken(1'b0), .branch_target(32'd0),
        .jump(1'b0), .jump_target(32'd0),
        .id_valid(id_valid2), .id_instr(id_instr2), .id_op(id_op2), .id_pc4(id_pc42)
`ifdef FETCH_PERF_EN
        , .fetch_count(fetch_count2)
`endif
    );

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_fail   = 0;

    int   wait_cycles = 0;
    int   budget = 0;
    int   mem_cnt = 0;
    bit   mem_busy = 0;
    logic [31:0] mem_addr = 32'd0;

    // Instruction word for an address: the opcode field varies with the address.
    function automatic logic [31:0] f(input logic [31:0] a);
        return {a[7:2], a[25:0]};
    endfunction

    task automatic push(input logic [31:0] a);
        exp_t e;
        e.instr = f(a);
        e.pc4   = a + 32'd4;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Memory model. It accepts a request at the negedge, waits wait_cycles,
    // then pulses imem_valid for one cycle. budget caps how many requests it
    // accepts, so the amount of traffic is fixed in advance.
    always @(negedge clk) begin
        imem_valid = 1'b0;
        if (reset) begin
            mem_busy = 0;
            mem_cnt  = 0;
        end else begin
            if (!mem_busy && imem_req && budget > 0) begin
                mem_busy = 1;
                mem_cnt  = 0;
                mem_addr = imem_addr;
                budget--;
            end
            if (mem_busy) begin
                if (mem_cnt == wait_cycles) begin
                    imem_valid = 1'b1;
                    imem_rdata = f(mem_addr);
                    mem_busy   = 0;
                end else begin
                    mem_cnt++;
                end
            end
        end
    end

    // Monitor. An IF/ID entry is consumed at any edge where stall is low.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && id_valid && !stall) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_id: got instr=%h pc4=%h, expected none", id_instr, id_pc4);
            end else begin
                e = exp_q.pop_front();
                if (id_instr !== e.instr || id_pc4 !== e.pc4 || id_op !== e.instr[31:26]) begin
                    n_fail++;
                    $display("FAIL id_entry: got instr=%h op=%h pc4=%h expected instr=%h op=%h pc4=%h",
                             id_instr, id_op, id_pc4, e.instr, e.instr[31:26], e.pc4);
                end else begin
                    n_pass++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_addr(input logic [31:0] a);
        bit hit;
        hit = 0;
        for (int i = 0; i < 50 && !hit; i++) begin
            tick();
            if (imem_req && imem_addr == a) hit = 1;
        end
        chk("wait_addr_reached", {31'd0, hit}, 32'd1);
    endtask

    task automatic drain_q();
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
        chk("queue_drained", exp_q.size(), 32'd0);
        exp_q.delete();
        tick();
        chk("bubble_after_drain", {31'd0, id_valid}, 32'd0);
    endtask

    task automatic do_reset(input int w, input int b);
        tick();
        reset = 1'b1;
        stall = 1'b0;
        branch_taken = 1'b0;
        jump = 1'b0;
        wait_cycles = w;
        budget = b;
        tick();
        tick();
    endtask

    initial begin
        #300000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset values
        repeat (3) tick();
        chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
        chk("rst_imem_addr", imem_addr, 32'd0);
        chk("rst_id_valid", {31'd0, id_valid}, 32'd0);
        chk("rst_id_instr", id_instr, 32'd0);
        chk("rst_id_op", {26'd0, id_op}, 32'd0);
        chk("rst_id_pc4", id_pc4, 32'd0);
        chk("rst2_imem_addr", imem_addr2, 32'hFFFF_FFFC);

        // Sequential fetch with zero-wait memory, plus the wrap-around instance
        wait_cycles = 0;
        budget = 4;
        push(32'h0); push(32'h4); push(32'h8); push(32'hC);
        reset = 1'b0;
        chk("first_req_delayed", {31'd0, imem_req}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("seq_imem_req", {31'd0, imem_req}, 32'd1);
            chk("seq_imem_addr", imem_addr, 32'(4 * i));
            if (i == 0) chk("wrap_first_addr", imem_addr2, 32'hFFFF_FFFC);
            if (i == 1) begin
                chk("wrap_second_addr", imem_addr2, 32'h0000_0000);
                chk("wrap_id_valid", {31'd0, id_valid2}, 32'd1);
                chk("wrap_id_instr", id_instr2, 32'hFFFF_FFFC);
                chk("wrap_id_op", {26'd0, id_op2}, 32'h3F);
                chk("wrap_id_pc4", id_pc42, 32'h0000_0000);
            end
`ifdef FETCH_PERF_EN
            if (i == 2) chk("wrap_fetch_count", fetch_count2, 32'd2);
`endif
        end
        drain_q();
`ifdef FETCH_PERF_EN
        chk("seq_fetch_count", fetch_count, 32'd4);
`endif

        // Stall for 3 cycles while the response for 0x10 arrives
        do_reset(0, 6);
        push(32'h0); push(32'h4); push(32'h8); push(32'hC); push(32'h10); push(32'h14);
        reset = 1'b0;
        wait_addr(32'h10);
        stall = 1'b1;
        tick();
        chk("hold_imem_req", {31'd0, imem_req}, 32'd0);
        chk("hold_id_valid", {31'd0, id_valid}, 32'd1);
        chk("hold_id_instr", id_instr, f(32'hC));
        chk("hold_id_pc4", id_pc4, 32'h10);
        tick();
        chk("hold2_imem_req", {31'd0, imem_req}, 32'd0);
        chk("hold2_id_pc4", id_pc4, 32'h10);
        tick();
        stall = 1'b0;
        tick();
        chk("unstall_id_instr", id_instr, f(32'h10));
        chk("unstall_imem_req", {31'd0, imem_req}, 32'd1);
        chk("unstall_imem_addr", imem_addr, 32'h14);
        drain_q();

        // Branch coincident with stall: flush wins, target low bits masked
        do_reset(0, 4);
        push(32'h0); push(32'h200);
        reset = 1'b0;
        wait_addr(32'h8);
        stall = 1'b1;
        branch_taken = 1'b1;
        branch_target = 32'h203;
        tick();
        stall = 1'b0;
        branch_taken = 1'b0;
        chk("flush_id_valid", {31'd0, id_valid}, 32'd0);
        chk("flush_imem_addr", imem_addr, 32'h200);
        chk("flush_imem_req", {31'd0, imem_req}, 32'd1);
        drain_q();

        // Branch and jump together (branch wins), then a jump on its own
        do_reset(0, 5);
        push(32'h0); push(32'h80); push(32'h40);
        reset = 1'b0;
        wait_addr(32'h4);
        jump = 1'b1;
        jump_target = 32'h40;
        branch_taken = 1'b1;
        branch_target = 32'h80;
        tick();
        jump = 1'b0;
        branch_taken = 1'b0;
        chk("prio_imem_addr", imem_addr, 32'h80);
        chk("prio_id_valid", {31'd0, id_valid}, 32'd0);
        wait_addr(32'h84);
        jump = 1'b1;
        jump_target = 32'h41;
        tick();
        jump = 1'b0;
        chk("jump_imem_addr", imem_addr, 32'h40);
        drain_q();

        // 2-wait memory, redirect one cycle into the request: drain, then refetch
        do_reset(2, 2);
        push(32'h100);
        reset = 1'b0;
        tick();
        tick();
        branch_taken = 1'b1;
        branch_target = 32'h100;
        tick();
        branch_taken = 1'b0;
        chk("drain_imem_req", {31'd0, imem_req}, 32'd0);
        chk("drain_id_valid", {31'd0, id_valid}, 32'd0);
        tick();
        chk("post_drain_imem_req", {31'd0, imem_req}, 32'd1);
        chk("post_drain_imem_addr", imem_addr, 32'h100);
        chk("post_drain_id_valid", {31'd0, id_valid}, 32'd0);
        drain_q();

        // Reset asserted mid-request returns everything to reset values
        do_reset(0, 3);
        push(32'h0);
        reset = 1'b0;
        tick();
        tick();
        tick();
        chk("mid_imem_addr", imem_addr, 32'h8);
        chk("mid_id_valid", {31'd0, id_valid}, 32'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_imem_req", {31'd0, imem_req}, 32'd0);
        chk("mid_rst_imem_addr", imem_addr, 32'd0);
        chk("mid_rst_id_valid", {31'd0, id_valid}, 32'd0);
        chk("mid_rst_id_instr", id_instr, 32'd0);
        chk("mid_rst_id_pc4", id_pc4, 32'd0);
`ifdef FETCH_PERF_EN
        chk("mid_rst_fetch_count", fetch_count, 32'd0);
`endif
        chk("mid_queue_drained", exp_q.size(), 32'd0);
        tick();
        reset = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
